router_pkt_tx: RTL

Packet source for the 1x3 router's input port. Latches a destination and a payload length, buffers the payload bytes, then emits header, payload and parity on the router's input bus under `busy` flow control. Used as the stimulus front-end in system benches and as the host-side transmitter in integrated builds. Parity is computed on the fly, and an optional corruption request exercises the router's `err` path.

---
 rtl/router_pkg.sv | 24 ++
 rtl/tx_payload_buf.sv | 27 ++
 rtl/router_pkt_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: header field widths, transmitter states and
// the header byte layout used by both the transmitter and the receive side.
package router_pkg;

    localparam int ADDR_W  = 2;
    localparam int LEN_W   = 6;
    localparam int MAX_LEN = 63;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PARITY  = 3'd4,
        ST_DONE    = 3'd5
    } tx_state_t;

    // Header byte: payload length in the upper six bits, destination in the lower two.
    function automatic logic [7:0] pack_header(input logic [LEN_W-1:0]  len,
                                               input logic [ADDR_W-1:0] dest);
        return {len, dest};
    endfunction

endpackage

// File: rtl/tx_payload_buf.sv
// Payload byte store for the packet transmitter: one synchronous write port
// and an asynchronous read port so payload bytes stream without a bubble.
module tx_payload_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write the loaded payload byte; storage carries no reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: latches dest/len, buffers the payload,
// then sends header, payload and parity under busy flow control.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN = 63
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest,
    input  logic [LEN_W-1:0]  len,
    input  logic              corrupt,
    output logic              cfg_err,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        data_out,
    output logic              pkt_valid,
    input  logic              busy,
    output logic              tx_active,
    output logic              done
);

    tx_state_t         state_q, state_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              corrupt_q, corrupt_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [7:0]        parity_q, parity_d;
    logic              cfg_err_q, cfg_err_d;

    logic              buf_we;
    logic [7:0]        buf_rdata;
    logic              cfg_ok;
    logic              last_idx;

    tx_payload_buf #(
        .DEPTH (64),
        .AW    (LEN_W),
        .DW    (8)
    ) u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (idx_q),
        .wdata (in_data),
        .raddr (idx_q),
        .rdata (buf_rdata)
    );

    assign cfg_ok   = (dest <= ADDR_W'(2)) && (len != '0) && (int'(len) <= MAX_LEN);
    assign last_idx = (idx_q == len_q - LEN_W'(1));

    // Control and datapath registers; reset aborts any packet in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dest_q    <= '0;
            len_q     <= '0;
            corrupt_q <= 1'b0;
            idx_q     <= '0;
            parity_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            len_q     <= len_d;
            corrupt_q <= corrupt_d;
            idx_q     <= idx_d;
            parity_q  <= parity_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state logic: request check, payload load and busy-gated transmission.
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        len_d     = len_q;
        corrupt_d = corrupt_q;
        idx_d     = idx_q;
        parity_d  = parity_q;
        cfg_err_d = 1'b0;
        buf_we    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        dest_d    = dest;
                        len_d     = len;
                        corrupt_d = corrupt;
                        idx_d     = '0;
                        state_d   = ST_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    if (last_idx) begin
                        idx_d    = '0;
                        // Seed parity with the header so it is ready when HEADER is sent.
                        parity_d = pack_header(len_q, dest_q);
                        state_d  = ST_HEADER;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            ST_HEADER: begin
                if (!busy) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!busy) begin
                    parity_d = parity_q ^ buf_rdata;
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only; busy never reaches an output directly.
    always_comb begin
        data_out  = 8'h00;
        pkt_valid = 1'b0;
        tx_active = 1'b0;
        in_ready  = (state_q == ST_LOAD);
        done      = (state_q == ST_DONE);
        cfg_err   = cfg_err_q;
        unique case (state_q)
            ST_HEADER: begin
                data_out  = pack_header(len_q, dest_q);
                pkt_valid = 1'b1;
                tx_active = 1'b1;
            end
            ST_PAYLOAD: begin
                data_out  = buf_rdata;
                pkt_valid = 1'b1;
                tx_active = 1'b1;
            end
            ST_PARITY: begin
                data_out  = parity_q ^ {7'b0, corrupt_q};
                tx_active = 1'b1;
            end
            default: begin
                data_out = 8'h00;
            end
        endcase
    end

endmodule
